// File: rtl/exmem_skid_register.sv
// EX/MEM pipeline boundary register: valid/ready handshake with a one-entry skid slot
// so the memory stage can stall execute without a combinational ready path.
module exmem_skid_register #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [REG_AW-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [REG_AW-1:0] dest,
  output logic [1:0]        occupancy
);

  // Payload layout: {wb_en, mem_r_en, mem_w_en, alu_result, st_val, dest}
  localparam int PW = 3 + 2 * DATA_W + REG_AW;

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_pl_q, main_pl_d;
  logic [PW-1:0] skid_pl_q, skid_pl_d;
  logic          in_ready_q, in_ready_d;
  logic [1:0]    occupancy_q, occupancy_d;

  logic [PW-1:0] in_pl;
  logic          accept;
  logic          pop;
  logic          main_wb, main_rd, main_wr;

  assign in_pl  = {wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, st_val_in, dest_in};
  assign accept = in_valid & in_ready_q;
  assign pop    = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_pl_d    = main_pl_q;
    skid_pl_d    = skid_pl_q;

    if (flush) begin
      // Drop everything, including a same-cycle input; only control bits are scrubbed.
      main_valid_d           = 1'b0;
      skid_valid_d           = 1'b0;
      main_pl_d[PW-1 -: 3]   = 3'b000;
      skid_pl_d[PW-1 -: 3]   = 3'b000;
    end else if (skid_valid_q) begin
      if (pop) begin
        main_pl_d    = skid_pl_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && pop) begin
        main_pl_d = in_pl;
      end else if (accept) begin
        skid_pl_d    = in_pl;
        skid_valid_d = 1'b1;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      main_pl_d    = in_pl;
      main_valid_d = 1'b1;
    end

    // Ready is computed from next-state so it is a plain flop output.
    in_ready_d  = ~skid_valid_d;
    occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_pl_q    <= '0;
      skid_pl_q    <= '0;
      in_ready_q   <= 1'b1;
      occupancy_q  <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_pl_q    <= main_pl_d;
      skid_pl_q    <= skid_pl_d;
      in_ready_q   <= in_ready_d;
      occupancy_q  <= occupancy_d;
    end
  end

  assign {main_wb, main_rd, main_wr, alu_result, st_val, dest} = main_pl_q;

  // A bubble must never write the register file or memory.
  assign wb_en     = main_wb & main_valid_q;
  assign mem_r_en  = main_rd & main_valid_q;
  assign mem_w_en  = main_wr & main_valid_q;
  assign out_valid = main_valid_q;
  assign in_ready  = in_ready_q;
  assign occupancy = occupancy_q;

endmodule
